// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states, iteration count and a sign-magnitude helper.
package mdu_pkg;

  localparam int MDU_WIDTH      = 32;
  localparam int MDU_ITERATIONS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } mdu_state_e;

  // Two's-complement magnitude of v when neg is set, v unchanged otherwise.
  function automatic logic [MDU_WIDTH-1:0] mag32(input logic [MDU_WIDTH-1:0] v,
                                                 input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO.
// Fixed latency: 32 radix-2 steps on magnitudes, then one sign fixup cycle.
// Handshake: start is a one-cycle request honoured only in IDLE; busy is high
// while an operation runs (CALC, FIXUP); done pulses for one cycle with hi/lo
// already holding the result. Requests while busy are dropped, not queued.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] write_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output mdu_state_e  dbg_state
);

  localparam logic [5:0] LAST_STEP = 6'(MDU_ITERATIONS - 1);

  mdu_state_e  r_state;
  mdu_state_e  w_next_state;
  logic [63:0] r_acc;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] r_m;        // multiplicand or divisor magnitude
  logic [5:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;    // negate product / quotient
  logic        r_neg_r;    // negate remainder

  logic        w_start_div;
  logic        w_start_signed;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_mul_sum;
  logic [32:0] w_rem_shift;
  logic        w_rem_ge;
  logic [31:0] w_rem_sub;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign dbg_state = r_state;

  // Operand decode at request time: signedness, signs and magnitudes.
  always_comb begin
    w_start_div    = (mdu_op_e'(op) == OP_DIV) || (mdu_op_e'(op) == OP_DIVU);
    w_start_signed = (mdu_op_e'(op) == OP_MULT) || (mdu_op_e'(op) == OP_DIV);
    w_sign_a       = w_start_signed & operand_a[31];
    w_sign_b       = w_start_signed & operand_b[31];
    w_mag_a        = mag32(operand_a, w_sign_a);
    w_mag_b        = mag32(operand_b, w_sign_b);
  end

  // One radix-2 step of shift-add multiply or restoring divide, plus fixup values.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
    w_rem_shift = r_acc[63:31];
    w_rem_ge    = (w_rem_shift >= {1'b0, r_m});
    w_rem_sub   = w_rem_shift[31:0] - r_m;
    if (r_is_div) begin
      w_step = {(w_rem_ge ? w_rem_sub : w_rem_shift[31:0]), r_acc[30:0], w_rem_ge};
    end else begin
      w_step = {w_mul_sum, r_acc[31:1]};
    end
    w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    // A zero divisor leaves the dividend as remainder; the quotient is forced.
    w_quo  = (r_m == 32'd0) ? 32'hFFFF_FFFF : mag32(r_acc[31:0], r_neg_q);
    w_rem  = mag32(r_acc[63:32], r_neg_r);
  end

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Controller next-state and status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (r_cnt == LAST_STEP) w_next_state = ST_FIXUP;
      end
      ST_FIXUP: begin
        busy         = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Working register, counter and latched operation attributes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc    <= {32'd0, (w_start_div ? w_mag_a : w_mag_b)};
            r_m      <= w_start_div ? w_mag_b : w_mag_a;
            r_cnt    <= '0;
            r_is_div <= w_start_div;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
          end
        end
        ST_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: direct loads while not busy, result write in FIXUP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (r_state == ST_FIXUP) begin
      if (r_is_div) begin
        hi <= w_rem;
        lo <= w_quo;
      end else begin
        hi <= w_prod[63:32];
        lo <= w_prod[31:0];
      end
    end else if (!busy) begin
      if (write_hi) hi <= write_data;
      if (write_lo) lo <= write_data;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised scoreboard bench for mult_div_unit: results predicted with
// plain 64-bit arithmetic, checked by a monitor on every done pulse.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  op;
  logic        start;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] write_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  mdu_state_e  dbg_state;

  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          done_cnt;

  mult_div_unit dut (
    .clock(clock), .reset(reset), .operand_a(operand_a), .operand_b(operand_b),
    .op(op), .start(start), .write_hi(write_hi), .write_lo(write_lo),
    .write_data(write_data), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: {hi,lo} from plain arithmetic on the operation's rules.
  function automatic logic [63:0] ref_result(input logic [1:0] f_op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f_op)
      2'b00: begin p = sa * sb; res = p; end
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("result_hi_lo", {hi, lo}, exp_q.pop_front());
        check("done_latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one operation; optionally disturb it while busy (second start plus
  // write_hi) or pair the start with a write_lo.
  task automatic run_op(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit wlo);
    int busy_cycles;
    int dc0;
    bit seen;
    @(negedge clock);
    dc0       = done_cnt;
    op        = f_op;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    if (wlo) begin
      write_lo   = 1'b1;
      write_data = 32'h0000_AAAA;
    end
    exp_q.push_back(ref_result(f_op, a, b));
    exp_cyc_q.push_back(cyc + 1 + 33);
    @(posedge clock);
    #1;
    start     = 1'b0;
    write_lo  = 1'b0;
    op        = 2'($urandom_range(0, 3));
    operand_a = $urandom;
    operand_b = $urandom;
    busy_cycles = 0;
    seen = 0;
    for (int i = 0; i < 45 && !seen; i++) begin
      @(negedge clock);
      if (wlo && i == 0) check("lo_after_write_with_start", {32'd0, lo}, 64'h0000_AAAA);
      if (busy) busy_cycles++;
      if (done) seen = 1;
      if (disturb && i == 5) begin
        start      = 1'b1;
        write_hi   = 1'b1;
        write_data = 32'h0000_1234;
      end
      if (disturb && i == 6) begin
        start    = 1'b0;
        write_hi = 1'b0;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(busy_cycles), 64'd33);
    @(negedge clock);
    check("done_single_pulse", {63'd0, done}, 64'd0);
    check("done_count", 64'(done_cnt - dc0), 64'd1);
  endtask

  // Start a DIVU and pull reset low at edge k+10; nothing may complete.
  task automatic reset_mid_op();
    int dc0;
    @(negedge clock);
    dc0       = done_cnt;
    op        = 2'b11;
    operand_a = 32'd1000;
    operand_b = 32'd7;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("rst_mid_no_done", 64'(done_cnt - dc0), 64'd0);
    check("rst_mid_hi_after", {hi, lo}, 64'd0);
  endtask

  // Direct HI/LO loads while idle.
  task automatic idle_writes(input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clock);
    write_hi = 1'b1; write_lo = 1'b1; write_data = d0;
    @(negedge clock);
    write_hi = 1'b0; write_lo = 1'b0;
    check("write_both", {hi, lo}, {d0, d0});
    write_hi = 1'b1; write_data = d1;
    @(negedge clock);
    write_hi = 1'b0;
    check("write_hi_only", {hi, lo}, {d1, d0});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; done_cnt = 0;
    reset = 1'b0; start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    write_data = '0; op = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clock);
    check("reset_hi_lo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("reset_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    reset = 1'b1;

    // Directed corner cases.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 0, 0);
    check("mult_neg7x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_neg7by2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd0, 0, 0);
    check("divu_by_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 0, 0);
    check("div_neg_by_zero", {hi, lo}, 64'hFFFF_FF00_FFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'b01, 32'd5, 32'd9, 1, 0);
    check("busy_ignores", {hi, lo}, 64'd45);
    idle_writes(32'hDEAD_BEEF, 32'h0BAD_F00D);
    reset_mid_op();
    run_op(2'b01, 32'd6, 32'd7, 0, 0);
    check("multu_6x7", {hi, lo}, 64'd42);
    run_op(2'b01, 32'd2, 32'd3, 0, 1);
    check("write_lo_with_start", {hi, lo}, 64'd6);

    // Randomised operations with biased operands.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, 0, 0);
    end

    repeat (2) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; the width is fixed at 32 bits and the iteration count is fixed at 32.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 operand_a  input  32  dividend or multiplicand, driven from register-file data_out_1.
REQ-005 operand_b  input  32  divisor or multiplier, driven from register-file data_out_2.
REQ-006 op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 start  input  1  one-cycle request; sampled only in IDLE.
REQ-008 write_hi / write_lo  input  1 each  direct HI/LO load (mthi/mtlo).
REQ-009 write_data  input  32  data for write_hi/write_lo.
REQ-010 hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 busy  output  1  high in CALC and FIXUP.
REQ-012 done  output  1  one-cycle pulse, high in DONE.

Function
REQ-013 SHALL implement four states: IDLE, CALC, FIXUP and DONE.
REQ-014 IDLE with start=1 at edge k: latch operand magnitudes, op and the result signs; clear the iteration counter; go to CALC.
REQ-015 CALC: one radix-2 step per edge (shift-add multiply, restoring divide) on unsigned magnitudes; after the 32nd step (edge k+32) go to FIXUP.
REQ-016 FIXUP (edge k+33): apply the sign correction, write hi/lo, go to DONE.
REQ-017 DONE: done=1 for exactly one cycle, then go to IDLE; hi/lo are valid in the same cycle done is high.
REQ-018 Total latency SHALL be fixed and data-independent, divide-by-zero included.
REQ-019 MULT/MULTU results SHALL be {hi,lo} = 64-bit product; signed operands use two's-complement magnitudes, and the product is negated when the operand signs differ.
REQ-020 DIV/DIVU results SHALL be lo=quotient, hi=remainder; signed quotient is negative iff the operand signs differ, and the remainder takes the dividend's sign.
REQ-021 Divide by zero SHALL give lo=0xFFFFFFFF and hi=operand_a as latched, for both DIV and DIVU.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-023 start outside IDLE SHALL be ignored; no queuing.
REQ-024 Operand and op changes after the start edge SHALL NOT affect the running operation.
REQ-025 write_hi/write_lo SHALL update the named register at the next edge when busy=0; they SHALL be ignored when busy=1.
REQ-026 write_hi or write_lo together with start in IDLE: the write SHALL take effect, and the later FIXUP overwrites both registers.
REQ-027 write_hi and write_lo in the same cycle SHALL load both registers with write_data.

Reset
REQ-028 reset low SHALL, asynchronously: set state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
REQ-029 reset asserted mid-operation SHALL discard the operation, produce no done pulse, and leave hi/lo at 0.
REQ-030 After reset deassertion the first start edge SHALL be accepted.

Structure
REQ-031 Shared package mdu_pkg SHALL hold the op encodings, the state enum and the constant MDU_ITERATIONS=32.
REQ-032 The block SHALL be one module with no sub-module; the multiply and divide datapaths share one 64-bit working register and one counter.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge k -> busy at k+1..k+33, done in cycle after k+33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, same latency as REQ-033; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-036 Second start plus write_hi=0x1234 while busy -> both ignored, only the first result appears, one done pulse.
REQ-037 reset low at edge k+10 of a DIVU -> hi=lo=0, busy=0, no done; new MULTU 6x7 afterwards -> lo=42, hi=0.
REQ-038 write_lo=0xAAAA with start (MULTU 2x3) in IDLE -> lo=0xAAAA next cycle, lo=6 and hi=0 at done.
